racod_cfg_issuer: RTL and testbench
===================================

Name: racod_cfg_issuer

Overview:
Host-side issuer for the RACOD collision-check core.
- Accepts the six 32-bit query fields over a narrow valid/ready word stream and packs them into the 192-bit configuration word.
- Issues that word with a single-cycle cfg_valid, waits a fixed result latency, samples the core's collision output, and returns the result over a valid/ready response channel.
- Sits between the query front-end (planner/host bridge) and racod_top.

Parameters:
WORD_W, 32, width of one configuration field and of the input word.
NUM_FIELDS, 6, fields per query; field order is origin_x, origin_y, length, width, sin_theta, cos_theta.
CFG_W, WORD_W*NUM_FIELDS (192), width of cfg_data; derived, not overridden.
RESULT_LAT, 8, cycles from cfg_valid to a valid collision output; legal range is 1..255.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_word  in  WORD_W  next query field
in_valid  in  1  in_word valid
in_ready  out  1  issuer accepts in_word
cfg_data  out  CFG_W  packed configuration to racod_top
cfg_valid  out  1  single-cycle configuration strobe
collision  in  1  collision result from racod_top
resp_valid  out  1  response available
resp_collision  out  1  collision result for the last query
resp_ready  in  1  consumer accepts response
busy  out  1  high in any state other than COLLECT, or when field index is non-zero
query_count  out  CNT_W  queries issued (saturating)
hit_count  out  CNT_W  collisions reported (saturating)

Behaviour:
- Single clock domain, clk. Reset rst is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values: state=COLLECT, idx=0, cfg_data=0, cfg_valid=0, resp_valid=0, resp_collision=0, counters=0, in_ready=1.
- States: COLLECT, ISSUE, WAIT, RESPOND. All outputs are registered or decoded from the registered state.
- COLLECT:
  - in_ready=1.
  - On in_valid&&in_ready: cfg_data[idx*WORD_W +: WORD_W] <= in_word and idx <= idx+1.
  - Field 0 (origin_x) lands in the LSBs; field 5 (cos_theta) lands in the MSBs.
  - Accepting the word with idx==NUM_FIELDS-1 sets idx <= 0 and moves to ISSUE.
- ISSUE:
  - Lasts exactly one cycle, with cfg_valid=1 and in_ready=0.
  - query_count <= query_count+1, saturating at all-ones.
  - cnt <= RESULT_LAT-1; next state is WAIT.
- WAIT:
  - If cnt==0: resp_collision <= collision, hit_count increments if collision (saturating), next state is RESPOND.
  - Otherwise cnt <= cnt-1.
  - collision is therefore sampled in the cycle ISSUE+RESULT_LAT.
- RESPOND:
  - resp_valid=1, held with a stable resp_collision until resp_ready.
  - On resp_valid&&resp_ready: next state is COLLECT. in_ready rises the following cycle.
- Latency: last field accepted at cycle T, so cfg_valid is high at T+1, collision is sampled at T+1+RESULT_LAT, and resp_valid first rises at T+2+RESULT_LAT.
- cfg_data is held stable from ISSUE until the first field of the next query is written. Fields never change while cfg_valid=1.
- in_valid outside COLLECT is ignored (in_ready=0), and no word is lost.
- resp_ready asserted before RESPOND has no effect.
- resp_ready already high on the first RESPOND cycle completes the handshake in that cycle: resp_valid is high for exactly one cycle.
- A query interrupted mid-collection completes normally only when all 6 fields arrive. Gaps on in_valid are allowed at any point.
- rst in any state aborts everything:
  - A partial query is discarded and a pending response is dropped.
  - No cfg_valid is produced for the aborted query.
  - The next cycle is COLLECT with idx=0.
- No back-to-back overlap: a new query cannot be collected while a response is pending.

Decomposition:
- Shared package racod_pkg holds:
  - RACOD_WORD_W=32 and RACOD_NUM_FIELDS=6.
  - Field index constants FLD_ORIGIN_X=0 .. FLD_COS=5.
  - The state enum typedef racod_iss_state_t (COLLECT, ISSUE, WAIT, RESPOND).
- One natural sub-module: racod_word_packer, which holds idx, the field-slot write into cfg_data, and the last-field flag.
- FSM, latency counter and statistics stay in racod_cfg_issuer.

Test Plan:
1. Basic query, RESULT_LAT=8: send words 1,2,3,4,5,6 back-to-back, with collision tied to 1 from ISSUE onward.
   -> cfg_data = {6,5,4,3,2,1} (32 bits each) with cfg_valid high exactly 1 cycle.
   -> resp_valid rises 10 cycles after the last accept, with resp_collision=1, query_count=1 and hit_count=1.
2. Gapped input: same 6 words, with in_valid dropped for 3 cycles between fields 2 and 3.
   -> cfg_data is identical, the cfg_valid pulse is single, and busy=1 from the first accepted word until the response handshake.
3. Backpressure: resp_ready held low for 5 cycles in RESPOND while in_valid=1 with new data.
   -> resp_valid and resp_collision stay stable, in_ready=0, no word is accepted, and cfg_data is unchanged.
4. Result sampling edge: collision pulses high only at cycle ISSUE+7, then only at ISSUE+8, in separate queries with RESULT_LAT=8.
   -> The first gives resp_collision=0; the second gives 1.
5. Reset mid-operation: assert rst after 3 fields, then once during WAIT.
   -> No cfg_valid for the aborted queries, counters=0, idx=0, and a following full query packs correctly from field 0.
6. Saturation: force 65537 collision queries (or preload via a short CNT_W=4 build, 17 queries).
   -> query_count and hit_count stick at all-ones with no wrap to 0.

Source files
------------

// File: rtl/racod_pkg.sv
// Shared constants and types for the RACOD host-side configuration issuer.
package racod_pkg;

  localparam int unsigned RACOD_WORD_W     = 32;
  localparam int unsigned RACOD_NUM_FIELDS = 6;

  // Field slot order inside the packed configuration word (slot 0 in the LSBs).
  localparam int unsigned FLD_ORIGIN_X = 0;
  localparam int unsigned FLD_ORIGIN_Y = 1;
  localparam int unsigned FLD_LENGTH   = 2;
  localparam int unsigned FLD_WIDTH    = 3;
  localparam int unsigned FLD_SIN      = 4;
  localparam int unsigned FLD_COS      = 5;

  typedef enum logic [1:0] {
    StCollect,
    StIssue,
    StWait,
    StRespond
  } racod_iss_state_t;

endpackage

// File: rtl/racod_word_packer.sv
// Packs successive query fields into the wide configuration word, slot by slot.
module racod_word_packer
  import racod_pkg::*;
#(
  parameter int unsigned WORD_W     = RACOD_WORD_W,
  parameter int unsigned NUM_FIELDS = RACOD_NUM_FIELDS,
  localparam int unsigned CFG_W     = WORD_W * NUM_FIELDS,
  localparam int unsigned IDX_W     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] word,
  output logic [CFG_W-1:0]  cfg_data,
  output logic [IDX_W-1:0]  idx,
  output logic              last
);

  logic [CFG_W-1:0] data_q;
  logic [IDX_W-1:0] idx_q;

  assign last     = (idx_q == IDX_W'(NUM_FIELDS - 1));
  assign cfg_data = data_q;
  assign idx      = idx_q;

  // data_q is only touched by an accepted word, so it stays stable through issue and wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      idx_q  <= '0;
    end else if (wr_en) begin
      data_q[idx_q*WORD_W +: WORD_W] <= word;
      idx_q                          <= last ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/racod_cfg_issuer.sv
// Collects a query, strobes it to the collision core, waits a fixed latency and
// returns the sampled collision result over a valid/ready response channel.
module racod_cfg_issuer
  import racod_pkg::*;
#(
  parameter int unsigned WORD_W     = RACOD_WORD_W,
  parameter int unsigned NUM_FIELDS = RACOD_NUM_FIELDS,
  parameter int unsigned RESULT_LAT = 8,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned CFG_W     = WORD_W * NUM_FIELDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CFG_W-1:0]  cfg_data,
  output logic              cfg_valid,
  input  logic              collision,
  output logic              resp_valid,
  output logic              resp_collision,
  input  logic              resp_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  query_count,
  output logic [CNT_W-1:0]  hit_count
);

  localparam int unsigned IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  racod_iss_state_t state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             resp_col_q, resp_col_d;
  logic [CNT_W-1:0] qcnt_q, qcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;

  logic             wr_en;
  logic             last;
  logic [IDX_W-1:0] idx;

  // Handshake outputs decode straight from the registered state.
  assign in_ready       = (state_q == StCollect);
  assign cfg_valid      = (state_q == StIssue);
  assign resp_valid     = (state_q == StRespond);
  assign resp_collision = resp_col_q;
  assign busy           = (state_q != StCollect) || (idx != '0);
  assign query_count    = qcnt_q;
  assign hit_count      = hcnt_q;
  assign wr_en          = in_valid && in_ready;

  racod_word_packer #(
    .WORD_W     (WORD_W),
    .NUM_FIELDS (NUM_FIELDS)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .word     (in_word),
    .cfg_data (cfg_data),
    .idx      (idx),
    .last     (last)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    resp_col_d = resp_col_q;
    qcnt_d     = qcnt_q;
    hcnt_d     = hcnt_q;
    unique case (state_q)
      StCollect: begin
        if (wr_en && last) state_d = StIssue;
      end
      StIssue: begin
        qcnt_d  = (&qcnt_q) ? qcnt_q : qcnt_q + 1'b1;
        cnt_d   = 8'(RESULT_LAT - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == 8'd0) begin
          resp_col_d = collision;
          if (collision && !(&hcnt_q)) hcnt_d = hcnt_q + 1'b1;
          state_d = StRespond;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StRespond: begin
        if (resp_ready) state_d = StCollect;
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCollect;
      cnt_q      <= '0;
      resp_col_q <= 1'b0;
      qcnt_q     <= '0;
      hcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      resp_col_q <= resp_col_d;
      qcnt_q     <= qcnt_d;
      hcnt_q     <= hcnt_d;
    end
  end

endmodule

// File: tb/tb_racod_cfg_issuer.sv
// Directed bench for racod_cfg_issuer: packing, latency, backpressure, reset, saturation.
module tb_racod_cfg_issuer;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_word;
  logic         in_valid;
  logic         in_ready;
  logic [191:0] cfg_data;
  logic         cfg_valid;
  logic         collision;
  logic         resp_valid;
  logic         resp_collision;
  logic         resp_ready;
  logic         busy;
  logic [15:0]  query_count;
  logic [15:0]  hit_count;

  // Second instance with narrow counters for saturation.
  logic         s_in_valid;
  logic         s_in_ready;
  logic [191:0] s_cfg_data;
  logic         s_cfg_valid;
  logic         s_resp_valid;
  logic         s_resp_collision;
  logic         s_busy;
  logic [3:0]   s_query_count;
  logic [3:0]   s_hit_count;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (cfg_valid) pulses <= pulses + 1;

  racod_cfg_issuer #(.RESULT_LAT(8), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_word        (in_word),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .cfg_data       (cfg_data),
    .cfg_valid      (cfg_valid),
    .collision      (collision),
    .resp_valid     (resp_valid),
    .resp_collision (resp_collision),
    .resp_ready     (resp_ready),
    .busy           (busy),
    .query_count    (query_count),
    .hit_count      (hit_count)
  );

  racod_cfg_issuer #(.RESULT_LAT(1), .CNT_W(4)) dut_sat (
    .clk            (clk),
    .rst            (rst),
    .in_word        (32'h0000_00A5),
    .in_valid       (s_in_valid),
    .in_ready       (s_in_ready),
    .cfg_data       (s_cfg_data),
    .cfg_valid      (s_cfg_valid),
    .collision      (1'b1),
    .resp_valid     (s_resp_valid),
    .resp_collision (s_resp_collision),
    .resp_ready     (1'b1),
    .busy           (s_busy),
    .query_count    (s_query_count),
    .hit_count      (s_hit_count)
  );

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    n        = 0;
    in_word  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check("send_timeout", 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_query(input logic [31:0] base);
    for (int i = 1; i <= 6; i++) send_word(base + 32'(i));
  endtask

  // Returns the number of edges until resp_valid is seen.
  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check("resp_timeout", 1'b0, 1'b1);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  function automatic logic [191:0] pack(input logic [31:0] base);
    logic [191:0] v;
    for (int i = 0; i < 6; i++) v[i*32 +: 32] = base + 32'(i + 1);
    return v;
  endfunction

  initial begin
    int           n;
    int           p0;
    int           rv_cycles;
    logic [191:0] snap;
    logic         rc;

    rst        = 1'b1;
    in_word    = '0;
    in_valid   = 1'b0;
    collision  = 1'b0;
    resp_ready = 1'b0;
    s_in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_in_ready", in_ready, 1'b1);
    check("rst_cfg_valid", cfg_valid, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_col", resp_collision, 1'b0);
    check("rst_cfg_data", cfg_data, 192'h0);
    check("rst_qcnt", query_count, 16'd0);
    check("rst_hcnt", hit_count, 16'd0);
    check("rst_busy", busy, 1'b0);

    // 1: basic query, collision tied high
    collision = 1'b1;
    p0 = pulses;
    send_query(32'h0);
    check("t1_cfg_valid", cfg_valid, 1'b1);
    check("t1_cfg_data", cfg_data, {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    check("t1_busy_issue", busy, 1'b1);
    wait_resp(n);
    check("t1_latency", 32'(n), 32'd9);
    check("t1_pulses", 32'(pulses - p0), 32'd1);
    check("t1_resp_col", resp_collision, 1'b1);
    check("t1_qcnt", query_count, 16'd1);
    check("t1_hcnt", hit_count, 16'd1);
    handshake();
    check("t1_resp_done", resp_valid, 1'b0);
    check("t1_in_ready", in_ready, 1'b1);

    // 2: gap of three cycles between fields 2 and 3
    collision = 1'b0;
    p0 = pulses;
    send_word(32'd1);
    send_word(32'd2);
    for (int i = 0; i < 3; i++) begin
      check("t2_busy_gap", busy, 1'b1);
      tick();
    end
    for (int i = 3; i <= 6; i++) send_word(32'(i));
    check("t2_cfg_data", cfg_data, {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    wait_resp(n);
    check("t2_busy_resp", busy, 1'b1);
    check("t2_pulses", 32'(pulses - p0), 32'd1);
    check("t2_resp_col", resp_collision, 1'b0);
    check("t2_qcnt", query_count, 16'd2);
    handshake();
    check("t2_busy_done", busy, 1'b0);

    // 3: response backpressure with new input pending
    collision = 1'b1;
    send_query(32'h1000);
    wait_resp(n);
    snap     = cfg_data;
    rc       = resp_collision;
    in_word  = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    check("t3_cfg_data", snap, pack(32'h1000));
    check("t3_resp_col", rc, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_resp_valid", resp_valid, 1'b1);
      check("t3_resp_stable", resp_collision, rc);
      check("t3_in_ready", in_ready, 1'b0);
      check("t3_cfg_hold", cfg_data, snap);
    end
    in_valid = 1'b0;
    handshake();
    check("t3_cfg_after", cfg_data, snap);
    check("t3_idle", busy, 1'b0);

    // 4: collision pulse one cycle early, then exactly on the sample cycle
    collision = 1'b0;
    send_query(32'h2000);
    for (int i = 0; i < 7; i++) tick();
    collision = 1'b1;
    tick();
    collision = 1'b0;
    wait_resp(n);
    check("t4_early_lat", 32'(n), 32'd1);
    check("t4_early_col", resp_collision, 1'b0);
    handshake();
    send_query(32'h3000);
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    collision = 1'b1;
    tick();
    collision = 1'b0;
    check("t4_exact_valid", resp_valid, 1'b1);
    check("t4_exact_col", resp_collision, 1'b1);
    rv_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) rv_cycles++;
      tick();
    end
    resp_ready = 1'b0;
    check("t4_one_cycle", 32'(rv_cycles), 32'd1);
    check("t4_qcnt", query_count, 16'd5);
    check("t4_hcnt", hit_count, 16'd3);

    // 5: reset mid-collection and during wait
    p0 = pulses;
    send_word(32'hA1);
    send_word(32'hA2);
    send_word(32'hA3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", busy, 1'b0);
    check("t5_cfg_clr", cfg_data, 192'h0);
    check("t5_qcnt", query_count, 16'd0);
    check("t5_hcnt", hit_count, 16'd0);
    for (int i = 0; i < 3; i++) tick();
    check("t5_no_pulse", 32'(pulses - p0), 32'd0);
    collision = 1'b1;
    send_query(32'h4000);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (resp_valid) rv_cycles = 99;
      tick();
    end
    check("t5_wait_no_resp", 32'(rv_cycles), 32'd1);
    check("t5_wait_qcnt", query_count, 16'd0);
    check("t5_wait_hcnt", hit_count, 16'd0);
    check("t5_wait_busy", busy, 1'b0);
    p0 = pulses;
    send_query(32'h5000);
    check("t5_repack", cfg_data, pack(32'h5000));
    wait_resp(n);
    check("t5_pulses", 32'(pulses - p0), 32'd1);
    check("t5_qcnt_new", query_count, 16'd1);
    handshake();

    // 6: four-bit counters saturate at 15
    s_in_valid = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      n = 0;
      while (!s_resp_valid && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) check("t6_timeout", 1'b0, 1'b1);
      if (k >= 14) begin
        check("t6_qcnt", s_query_count, (k > 15) ? 4'd15 : 4'(k));
        check("t6_hcnt", s_hit_count, (k > 15) ? 4'd15 : 4'(k));
      end
      tick();
    end
    s_in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
